// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: stage valids, MEM/WB dest shadows, stalls,
// redirects, operand forwarding selects and ECALL/EBREAK drain-to-halt.
module pipe_hazard_ctrl #(
  parameter int IW  = 32,
  parameter int DW  = 32,
  parameter int RFW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_valid,
  input  logic [IW-1:0] id_inst,
  input  logic [IW-1:0] ex_inst,
  input  logic [DW-1:0] ex_result,
  input  logic          mem_busy,
  output logic          pc_en,
  output logic          id_en,
  output logic          ex_en,
  output logic          mem_en,
  output logic          wb_en,
  output logic          id_valid,
  output logic          ex_valid,
  output logic          mem_valid,
  output logic          wb_valid,
  output logic          redirect,
  output logic          redirect_src,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          halted
);

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_OPIMM  = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

  state_t state, state_n;

  logic [RFW-1:0] mem_rd, wb_rd;
  logic           mem_wr, wb_wr;
  logic           flush_id, kill_ex, kill_mem;
  logic           redir_c, sys_c, lu_c;
  logic [4:0]     ex_op;
  logic           unused_bits;

  function automatic logic writes(input logic [IW-1:0] i);
    logic [4:0] op;
    op = i[6:2];
    return (op == OP_OP || op == OP_OPIMM || op == OP_LOAD ||
            op == OP_LUI || op == OP_AUIPC || op == OP_JAL ||
            op == OP_JALR) && (i[7 +: RFW] != '0);
  endfunction

  function automatic logic use1(input logic [IW-1:0] i);
    logic [4:0] op;
    op = i[6:2];
    return op == OP_OP || op == OP_OPIMM || op == OP_LOAD ||
           op == OP_STORE || op == OP_BRANCH || op == OP_JALR;
  endfunction

  function automatic logic use2(input logic [IW-1:0] i);
    logic [4:0] op;
    op = i[6:2];
    return op == OP_OP || op == OP_STORE || op == OP_BRANCH;
  endfunction

  // MEM wins over WB: it holds the younger write.
  function automatic logic [1:0] fsel(
    input logic           en,
    input logic [RFW-1:0] rs,
    input logic           mv,
    input logic           mw,
    input logic [RFW-1:0] mr,
    input logic           wv,
    input logic           ww,
    input logic [RFW-1:0] wr
  );
    if (!en)                      return 2'b00;
    if (mv && mw && mr == rs)     return 2'b01;
    if (wv && ww && wr == rs)     return 2'b10;
    return 2'b00;
  endfunction

  assign ex_op   = ex_inst[6:2];
  assign redir_c = ex_valid && (ex_op == OP_JAL || ex_op == OP_JALR ||
                   (ex_op == OP_BRANCH && ex_result[0]));
  assign sys_c   = ex_valid && ex_op == OP_SYSTEM;
  assign lu_c    = ex_valid && ex_op == OP_LOAD && writes(ex_inst) &&
                   id_valid &&
                   ((use1(id_inst) && id_inst[15 +: RFW] == ex_inst[7 +: RFW]) ||
                    (use2(id_inst) && id_inst[20 +: RFW] == ex_inst[7 +: RFW]));

  assign fwd_a = rst ? 2'b00 :
    fsel(ex_valid && use1(ex_inst), ex_inst[15 +: RFW],
         mem_valid, mem_wr, mem_rd, wb_valid, wb_wr, wb_rd);
  assign fwd_b = rst ? 2'b00 :
    fsel(ex_valid && use2(ex_inst), ex_inst[20 +: RFW],
         mem_valid, mem_wr, mem_rd, wb_valid, wb_wr, wb_rd);

  assign halted = state == HALT;

  assign unused_bits = ^{ex_result[DW-1:1], id_inst[IW-1:25],
                         id_inst[14:7], id_inst[1:0], ex_inst[IW-1:25],
                         ex_inst[14:12], ex_inst[1:0]};

  always_comb begin
    state_n      = state;
    pc_en        = 1'b0;
    id_en        = 1'b0;
    ex_en        = 1'b0;
    mem_en       = 1'b0;
    wb_en        = 1'b0;
    redirect     = 1'b0;
    redirect_src = 1'b0;
    flush_id     = 1'b0;
    kill_ex      = 1'b0;
    kill_mem     = 1'b0;
    if (!rst && !mem_busy) begin
      unique case (state)
        RUN: begin
          {pc_en, id_en, ex_en, mem_en, wb_en} = 5'b11111;
          if (redir_c) begin
            redirect     = 1'b1;
            redirect_src = ex_op == OP_BRANCH;
            flush_id     = 1'b1;
            kill_ex      = 1'b1;
          end else if (sys_c) begin
            {pc_en, id_en} = 2'b00;
            flush_id       = 1'b1;
            kill_ex        = 1'b1;
            kill_mem       = 1'b1;
            state_n        = DRAIN;
          end else if (lu_c) begin
            {pc_en, id_en} = 2'b00;
            kill_ex        = 1'b1;
          end
        end
        DRAIN: begin
          mem_en = 1'b1;
          wb_en  = 1'b1;
          if (!mem_valid && !wb_valid) state_n = HALT;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      id_valid  <= 1'b0;
      ex_valid  <= 1'b0;
      mem_valid <= 1'b0;
      wb_valid  <= 1'b0;
      mem_rd    <= '0;
      mem_wr    <= 1'b0;
      wb_rd     <= '0;
      wb_wr     <= 1'b0;
    end else begin
      state <= state_n;
      if (flush_id)   id_valid <= 1'b0;
      else if (id_en) id_valid <= fetch_valid;
      if (ex_en) ex_valid <= id_valid && !kill_ex;
      if (mem_en) begin
        mem_valid <= ex_valid && !kill_mem;
        mem_rd    <= ex_inst[7 +: RFW];
        mem_wr    <= writes(ex_inst);
      end
      if (wb_en) begin
        wb_valid <= mem_valid;
        wb_rd    <= mem_rd;
        wb_wr    <= mem_wr;
      end
    end
  end

endmodule
